// File: rtl/unidade_controle_rodadas_pkg.sv
// State encodings for the round-based memory game controller.
// The same codes drive the 7-segment debug display.
package unidade_controle_rodadas_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hC,
        FIM_ERRO       = 4'hE
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hF;

    function automatic logic [3:0] db_codigo(input estado_t e);
        logic [3:0] c;
        case (e)
            INICIAL,
            PREPARACAO,
            INICIA_RODADA,
            ESPERA,
            REGISTRA,
            COMPARACAO,
            PROXIMO,
            PROXIMA_RODADA,
            FIM_ACERTO,
            FIM_TIMEOUT,
            FIM_ERRO: c = e;
            default:  c = DB_ILEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear and count enable.
// o_fim flags the terminal value M-1.
module contador_m #(
    parameter  int M = 16,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_zera,
    input  logic         i_conta,
    output logic [W-1:0] o_q,
    output logic         o_fim
);

    logic [W-1:0] r_q;
    logic         w_fim;

    assign w_fim = (r_q == W'(M - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_zera) begin
            r_q <= '0;
        end else if (i_conta) begin
            r_q <= w_fim ? '0 : r_q + 1'b1;
        end
    end

    assign o_q   = r_q;
    assign o_fim = w_fim;

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control FSM for the memory-sequence game with rounds.
// Owns the address, round and play-timeout counters.
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter  int N_JOGADAS      = 16,
    parameter  int TIMEOUT_CICLOS = 5000,
    parameter  bit TIMEOUT_EN     = 1'b1,
    localparam int AW             = $clog2(N_JOGADAS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_iniciar,
    input  logic          i_jogada,
    input  logic          i_igual,
    output logic          o_zeraR,
    output logic          o_registraR,
    output logic [AW-1:0] o_endereco,
    output logic [AW-1:0] o_rodada,
    output logic          o_pronto,
    output logic          o_acertou,
    output logic          o_errou,
    output logic          o_timeout,
    output logic [3:0]    o_db_estado
);

    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    estado_t       r_estado;
    estado_t       w_proximo;
    logic [AW-1:0] r_endereco;
    logic [AW-1:0] r_rodada;
    logic [TW-1:0] w_timer;
    logic          w_timer_fim;
    logic          w_timer_zera;
    logic          w_timer_conta;
    logic          w_estouro;

    assign w_estouro = TIMEOUT_EN && (w_timer == TW'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:
                w_proximo = i_iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:
                w_proximo = INICIA_RODADA;
            INICIA_RODADA:
                w_proximo = ESPERA;
            ESPERA:
                if (i_jogada)       w_proximo = REGISTRA;
                else if (w_estouro) w_proximo = FIM_TIMEOUT;
                else                w_proximo = ESPERA;
            REGISTRA:
                w_proximo = COMPARACAO;
            COMPARACAO:
                if (!i_igual)
                    w_proximo = FIM_ERRO;
                else if (r_endereco != r_rodada)
                    w_proximo = PROXIMO;
                else if (r_rodada == AW'(N_JOGADAS - 1))
                    w_proximo = FIM_ACERTO;
                else
                    w_proximo = PROXIMA_RODADA;
            PROXIMO:
                w_proximo = ESPERA;
            PROXIMA_RODADA:
                w_proximo = INICIA_RODADA;
            FIM_ACERTO:
                w_proximo = i_iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:
                w_proximo = i_iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT:
                w_proximo = i_iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:
                w_proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_endereco <= '0;
            r_rodada   <= '0;
        end else begin
            case (r_estado)
                PREPARACAO: begin
                    r_endereco <= '0;
                    r_rodada   <= '0;
                end
                INICIA_RODADA:  r_endereco <= '0;
                PROXIMO:        r_endereco <= r_endereco + 1'b1;
                PROXIMA_RODADA: r_rodada   <= r_rodada + 1'b1;
                default: ;
            endcase
        end
    end

    // Holding at the terminal value makes the timer saturate when timeout is off
    assign w_timer_zera  = (r_estado == PREPARACAO) ||
                           (r_estado == INICIA_RODADA) ||
                           (r_estado == REGISTRA) ||
                           (r_estado == PROXIMO);
    assign w_timer_conta = (r_estado == ESPERA) && !i_jogada && !w_timer_fim;

    contador_m #(
        .M (TIMEOUT_CICLOS)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .i_zera  (w_timer_zera),
        .i_conta (w_timer_conta),
        .o_q     (w_timer),
        .o_fim   (w_timer_fim)
    );

    always_comb begin
        o_zeraR     = 1'b0;
        o_registraR = 1'b0;
        o_pronto    = 1'b0;
        o_acertou   = 1'b0;
        o_errou     = 1'b0;
        o_timeout   = 1'b0;
        case (r_estado)
            INICIAL,
            PREPARACAO:  o_zeraR     = 1'b1;
            REGISTRA:    o_registraR = 1'b1;
            FIM_ACERTO: begin
                o_pronto  = 1'b1;
                o_acertou = 1'b1;
            end
            FIM_ERRO: begin
                o_pronto = 1'b1;
                o_errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                o_pronto  = 1'b1;
                o_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_endereco  = r_endereco;
    assign o_rodada    = r_rodada;
    assign o_db_estado = db_codigo(r_estado);

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Self-checking bench for the round-based game controller.
// Two instances: timeout enabled (a) and disabled (b).
module tb_unidade_controle_rodadas;
    import unidade_controle_rodadas_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       a_ini = 0, a_jog = 0, a_igu = 0;
    logic       a_zr, a_rg, a_pr, a_ac, a_er, a_to;
    logic [1:0] a_en, a_ro;
    logic [3:0] a_db;
    logic       b_ini = 0, b_jog = 0, b_igu = 0;
    logic       b_zr, b_rg, b_pr, b_ac, b_er, b_to;
    logic [1:0] b_en, b_ro;
    logic [3:0] b_db;

    unidade_controle_rodadas #(
        .N_JOGADAS(4), .TIMEOUT_CICLOS(10), .TIMEOUT_EN(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset),
        .i_iniciar(a_ini), .i_jogada(a_jog), .i_igual(a_igu),
        .o_zeraR(a_zr), .o_registraR(a_rg),
        .o_endereco(a_en), .o_rodada(a_ro),
        .o_pronto(a_pr), .o_acertou(a_ac), .o_errou(a_er),
        .o_timeout(a_to), .o_db_estado(a_db)
    );

    unidade_controle_rodadas #(
        .N_JOGADAS(4), .TIMEOUT_CICLOS(10), .TIMEOUT_EN(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset),
        .i_iniciar(b_ini), .i_jogada(b_jog), .i_igual(b_igu),
        .o_zeraR(b_zr), .o_registraR(b_rg),
        .o_endereco(b_en), .o_rodada(b_ro),
        .o_pronto(b_pr), .o_acertou(b_ac), .o_errou(b_er),
        .o_timeout(b_to), .o_db_estado(b_db)
    );

    logic [13:0] a_out, b_out;
    assign a_out = {a_db, a_en, a_ro, a_zr, a_rg, a_pr, a_ac, a_er, a_to};
    assign b_out = {b_db, b_en, b_ro, b_zr, b_rg, b_pr, b_ac, b_er, b_to};

    typedef struct {
        string       lbl;
        bit          sel;
        logic [13:0] v;
        logic [13:0] m;
    } exp_t;

    typedef struct {
        logic       ini, jog, igu;
        estado_t    st;
        logic [1:0] en, ro;
    } vec_t;

    exp_t sb[$];
    vec_t tab[12];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [13:0] modelo(logic [3:0] st, logic [1:0] en, logic [1:0] ro);
        logic zr, rg, pr, ac, er, to;
        zr = (st == 4'h0) || (st == 4'h1);
        rg = (st == 4'h4);
        ac = (st == 4'hA);
        er = (st == 4'hE);
        to = (st == 4'hC);
        pr = ac || er || to;
        return {st, en, ro, zr, rg, pr, ac, er, to};
    endfunction

    task automatic push(string lbl, bit sel, logic [3:0] st,
                        logic [1:0] en, logic [1:0] ro, bit cnt);
        exp_t e;
        e.lbl = lbl;
        e.sel = sel;
        e.v   = modelo(st, en, ro);
        e.m   = cnt ? 14'h3FFF : 14'h3C3F;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [13:0] act;
        e   = sb.pop_front();
        act = e.sel ? b_out : a_out;
        n_vec++;
        if (((act ^ e.v) & e.m) != 14'h0) begin
            n_err++;
            $display("FAIL %s: got %h want %h (mask %h)", e.lbl, act, e.v, e.m);
        end
    endtask

    task automatic step(string lbl, bit sel, logic ini, logic jog, logic igu,
                        logic [3:0] st, logic [1:0] en, logic [1:0] ro,
                        bit cnt = 1'b1);
        if (sel) begin
            b_ini = ini; b_jog = jog; b_igu = igu;
        end else begin
            a_ini = ini; a_jog = jog; a_igu = igu;
        end
        push(lbl, sel, st, en, ro, cnt);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic now(string lbl, bit sel, logic [3:0] st,
                       logic [1:0] en, logic [1:0] ro);
        push(lbl, sel, st, en, ro, 1'b1);
        pop_check();
    endtask

    // Enters from espera with endereco=0 of round r; bad_e<0 plays clean
    task automatic play_round(int r, int bad_e);
        for (int e = 0; e <= r; e++) begin
            step("reg", 0, 0, 1, 0, REGISTRA, 2'(e), 2'(r));
            step("cmp", 0, 0, 0, 0, COMPARACAO, 2'(e), 2'(r));
            if (e == bad_e) begin
                step("erro", 0, 0, 0, 0, FIM_ERRO, 2'(e), 2'(r));
                return;
            end
            if (e != r) begin
                step("prox", 0, 0, 0, 1, PROXIMO, 2'(e), 2'(r));
                step("esp", 0, 0, 0, 0, ESPERA, 2'(e + 1), 2'(r));
            end else if (r == 3) begin
                step("acerto", 0, 0, 0, 1, FIM_ACERTO, 2'(e), 2'(r));
            end else begin
                step("proxr", 0, 0, 0, 1, PROXIMA_RODADA, 2'(e), 2'(r));
                step("inir", 0, 0, 0, 0, INICIA_RODADA, 2'(e), 2'(r + 1));
                step("esp0", 0, 0, 0, 0, ESPERA, 2'd0, 2'(r + 1));
            end
        end
    endtask

    task automatic novo_jogo(bit sel);
        step("prep", sel, 1, 0, 0, PREPARACAO, 2'd0, 2'd0, 1'b0);
        step("inic", sel, 0, 0, 0, INICIA_RODADA, 2'd0, 2'd0);
        step("esp", sel, 0, 0, 0, ESPERA, 2'd0, 2'd0);
    endtask

    initial begin
        tab[0]  = '{0, 1, 0, INICIAL,        2'd0, 2'd0};
        tab[1]  = '{0, 0, 1, INICIAL,        2'd0, 2'd0};
        tab[2]  = '{1, 0, 0, PREPARACAO,     2'd0, 2'd0};
        tab[3]  = '{1, 0, 0, INICIA_RODADA,  2'd0, 2'd0};
        tab[4]  = '{0, 0, 0, ESPERA,         2'd0, 2'd0};
        tab[5]  = '{0, 0, 0, ESPERA,         2'd0, 2'd0};
        tab[6]  = '{1, 0, 0, ESPERA,         2'd0, 2'd0};
        tab[7]  = '{0, 1, 0, REGISTRA,       2'd0, 2'd0};
        tab[8]  = '{1, 1, 0, COMPARACAO,     2'd0, 2'd0};
        tab[9]  = '{0, 0, 1, PROXIMA_RODADA, 2'd0, 2'd0};
        tab[10] = '{1, 0, 0, INICIA_RODADA,  2'd0, 2'd1};
        tab[11] = '{0, 0, 0, ESPERA,         2'd0, 2'd1};

        #2;
        now("reset", 0, INICIAL, 2'd0, 2'd0);
        now("reset_b", 1, INICIAL, 2'd0, 2'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++)
            step($sformatf("tab%0d", i), 0, tab[i].ini, tab[i].jog,
                 tab[i].igu, tab[i].st, tab[i].en, tab[i].ro);

        play_round(1, -1);
        play_round(2, -1);
        play_round(3, -1);
        step("hold_acerto", 0, 0, 1, 0, FIM_ACERTO, 2'd3, 2'd3);

        novo_jogo(0);
        play_round(0, -1);
        play_round(1, -1);
        play_round(2, 1);
        step("hold_erro", 0, 0, 1, 1, FIM_ERRO, 2'd1, 2'd2);

        novo_jogo(0);
        for (int k = 1; k < 10; k++)
            step($sformatf("espera%0d", k), 0, 0, 0, 0, ESPERA, 2'd0, 2'd0);
        step("timeout", 0, 0, 0, 0, FIM_TIMEOUT, 2'd0, 2'd0);
        step("hold_to", 0, 0, 1, 0, FIM_TIMEOUT, 2'd0, 2'd0);

        novo_jogo(0);
        play_round(0, -1);
        for (int k = 1; k < 10; k++)
            step("lim_esp", 0, 0, 0, 0, ESPERA, 2'd0, 2'd1);
        step("lim_jog", 0, 0, 1, 0, REGISTRA, 2'd0, 2'd1);
        step("lim_cmp", 0, 0, 0, 0, COMPARACAO, 2'd0, 2'd1);
        step("lim_prox", 0, 0, 0, 1, PROXIMO, 2'd0, 2'd1);
        step("lim_esp1", 0, 0, 0, 0, ESPERA, 2'd1, 2'd1);
        for (int k = 1; k < 10; k++)
            step("rest_esp", 0, 0, 0, 0, ESPERA, 2'd1, 2'd1);
        step("rest_to", 0, 0, 0, 0, FIM_TIMEOUT, 2'd1, 2'd1);

        novo_jogo(0);
        play_round(0, -1);
        step("r1_reg", 0, 0, 1, 0, REGISTRA, 2'd0, 2'd1);
        step("r1_cmp", 0, 0, 0, 1, COMPARACAO, 2'd0, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        now("async_rst", 0, INICIAL, 2'd0, 2'd0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        step("jog_inicial", 0, 0, 1, 0, INICIAL, 2'd0, 2'd0);

        novo_jogo(1);
        for (int k = 0; k < 30; k++)
            step("b_espera", 1, 0, 0, 0, ESPERA, 2'd0, 2'd0);
        step("b_jog", 1, 0, 1, 0, REGISTRA, 2'd0, 2'd0);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
